// File: rtl/operand_host_if.sv
// Host-side writer for the 4-bit add datapath: loads two operands into R1/R2,
// kicks the compute sequencer, waits for done (or times out) and returns the result.
module operand_host_if #(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] wr_data,
   output logic             wr_r1,
   output logic             wr_r2,
   output logic             start,
   input  logic             done,
   input  logic [WIDTH-1:0] result_in,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err,
   output logic             busy,
   output logic [2:0]       state_dbg
);

   // Both channels are valid/ready: a transfer happens on the rising edge where
   // valid and ready are both high; valid must stay up and its data stable until then.

   localparam logic [2:0] GET_A = 3'd0;
   localparam logic [2:0] GET_B = 3'd1;
   localparam logic [2:0] START = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] RESP  = 3'd4;

   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   logic [2:0]    state;
   logic [TW-1:0] timer;
   logic          in_accept;
   logic          out_accept;
   logic          timed_out;

   assign in_ready   = (state == GET_A) || (state == GET_B);
   assign busy       = (state != GET_A);
   assign state_dbg  = state;
   assign in_accept  = in_valid && in_ready;
   assign out_accept = out_valid && out_ready;
   assign timed_out  = (timer == TIMER_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= GET_A;
         timer     <= '0;
         wr_data   <= '0;
         wr_r1     <= 1'b0;
         wr_r2     <= 1'b0;
         start     <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         // Strobes are single-cycle: cleared every edge unless re-raised below.
         wr_r1 <= 1'b0;
         wr_r2 <= 1'b0;
         start <= 1'b0;
         case (state)
            GET_A: begin
               if (in_accept) begin
                  wr_data <= in_data;
                  wr_r1   <= 1'b1;
                  state   <= GET_B;
               end
            end
            GET_B: begin
               if (in_accept) begin
                  wr_data <= in_data;
                  wr_r2   <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               start <= 1'b1;
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               timer <= timer + 1'b1;
               // A done arriving in the timeout cycle still counts as success.
               if (done) begin
                  out_data  <= result_in;
                  err       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= RESP;
               end else if (timed_out) begin
                  out_data  <= '0;
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (out_accept) begin
                  out_valid <= 1'b0;
                  err       <= 1'b0;
                  state     <= GET_A;
               end
            end
            default: begin
               state <= GET_A;
            end
         endcase
      end
   end

endmodule
